// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;
   localparam int MULDIV_WIDTH = 32;
   localparam int MULDIV_ITERS = MULDIV_WIDTH;
   localparam logic [MULDIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

   typedef enum logic [1:0] {IDLE, CALC, FIXUP} muldiv_state_t;
endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: absolute values on entry, conditional negation on exit.
// Wide mode negates the full 2*W product; split mode negates HI and LO halves independently.
module muldiv_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           is_unsigned,
   output logic [W-1:0]   abs_a,
   output logic [W-1:0]   abs_b,
   output logic           neg_a,
   output logic           neg_b,
   input  logic [2*W-1:0] fix_in,
   input  logic           fix_wide,
   input  logic           fix_neg_hi,
   input  logic           fix_neg_lo,
   output logic [2*W-1:0] fix_out
);
   assign neg_a = !is_unsigned && a[W-1];
   assign neg_b = !is_unsigned && b[W-1];
   assign abs_a = neg_a ? -a : a;
   assign abs_b = neg_b ? -b : b;

   always_comb begin
      fix_out = fix_in;
      if (fix_wide) begin
         if (fix_neg_hi) fix_out = -fix_in;
      end else begin
         if (fix_neg_hi) fix_out[2*W-1:W] = -fix_in[2*W-1:W];
         if (fix_neg_lo) fix_out[W-1:0]   = -fix_in[W-1:0];
      end
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/DIV unit owning HI/LO; result WIDTH+2 edges after request.
// Stalls the control path from the request cycle through the last CALC cycle; MTHI/MTLO never stall.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             exec,
   input  logic             mul,
   input  logic             div,
   input  logic             is_unsigned,
   input  logic             write_hi,
   input  logic             write_lo,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             stall,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(MULDIV_ITERS);

   muldiv_state_t      state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   orig_a;
   logic               op_mul;
   logic               sgn_diff;
   logic               sgn_dvd;
   logic               div_zero;

   logic               request;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic               neg_a;
   logic               neg_b;
   logic [2*WIDTH-1:0] fix_out;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_diff;

   assign request = exec && (mul || div);
   assign stall   = !reset && ((state == IDLE && request) || state == CALC);

   // Multiply: acc = {partial product, remaining multiplier bits}; add-then-shift-right.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
   // Divide: acc = {remainder, dividend bits still to shift in}; trial subtract of divisor.
   assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

   muldiv_signfix #(.W(WIDTH)) u_signfix (
      .a          (op_a),
      .b          (op_b),
      .is_unsigned(is_unsigned),
      .abs_a      (abs_a),
      .abs_b      (abs_b),
      .neg_a      (neg_a),
      .neg_b      (neg_b),
      .fix_in     (acc),
      .fix_wide   (op_mul),
      .fix_neg_hi (op_mul ? sgn_diff : sgn_dvd),
      .fix_neg_lo (sgn_diff),
      .fix_out    (fix_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         orig_a   <= '0;
         op_mul   <= 1'b0;
         sgn_diff <= 1'b0;
         sgn_dvd  <= 1'b0;
         div_zero <= 1'b0;
         busy     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (exec && write_hi) hi <= op_a;
               if (exec && write_lo) lo <= op_a;
               if (request) begin
                  op_mul   <= mul;
                  sgn_diff <= neg_a ^ neg_b;
                  sgn_dvd  <= neg_a;
                  div_zero <= !mul && (op_b == '0);
                  orig_a   <= op_a;
                  opnd     <= mul ? abs_a : abs_b;
                  acc      <= {{WIDTH{1'b0}}, (mul ? abs_b : abs_a)};
                  cnt      <= CW'(MULDIV_ITERS - 1);
                  busy     <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (op_mul)
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               else if (!div_diff[WIDTH])
                  acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else
                  acc <= {acc[2*WIDTH-2:0], 1'b0};
               cnt <= cnt - CW'(1);
               if (cnt == '0) state <= FIXUP;
            end
            FIXUP: begin
               if (!op_mul && div_zero) begin
                  hi <= orig_a;
                  lo <= DIV_ZERO_QUOT;
               end else begin
                  {hi, lo} <= fix_out;
               end
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and random checks of the multiply/divide sequencer against an arithmetic reference.
module tb_muldiv_sequencer;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         exec;
   logic         mul;
   logic         div;
   logic         is_unsigned;
   logic         write_hi;
   logic         write_lo;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         stall;
   logic         busy;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_assert = 0;
   int n_fail   = 0;

   muldiv_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .exec       (exec),
      .mul        (mul),
      .div        (div),
      .is_unsigned(is_unsigned),
      .write_hi   (write_hi),
      .write_lo   (write_lo),
      .op_a       (op_a),
      .op_b       (op_b),
      .stall      (stall),
      .busy       (busy),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drop_req();
      exec = 1'b0;
      mul  = 1'b0;
      div  = 1'b0;
   endtask

   // Reference: {hi, lo} from plain integer arithmetic.
   function automatic logic [2*W-1:0] ref_model(input bit is_mul, input bit uns,
                                                 input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] sa, sb, sp;
      logic signed [W-1:0]   q, r;
      if (is_mul) begin
         if (uns) return {{W{1'b0}}, a} * {{W{1'b0}}, b};
         sa = {{W{a[W-1]}}, a};
         sb = {{W{b[W-1]}}, b};
         sp = sa * sb;
         return sp;
      end
      if (b == '0) return {a, {W{1'b1}}};
      if (uns) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
   endfunction

   task automatic do_op(input string tag, input bit is_mul, input bit uns,
                        input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      int  stall_cnt;
      int  busy_cnt;
      int  edges;
      bit  done;
      exec        = 1'b1;
      mul         = is_mul;
      div         = !is_mul;
      is_unsigned = uns;
      op_a        = a;
      op_b        = b;
      #1;
      stall_cnt = stall ? 1 : 0;
      busy_cnt  = 0;
      edges     = 0;
      done      = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(posedge clk);
         #1;
         edges++;
         if (busy) busy_cnt++;
         else done = 1'b1;
         if (!busy || !hold) drop_req();
         #1;
         if (stall) stall_cnt++;
      end
      chk({tag, "_done"}, W'(done), W'(1));
      chk({tag, "_stall_cycles"}, W'(stall_cnt), W'(W + 1));
      chk({tag, "_busy_cycles"}, W'(busy_cnt), W'(W + 1));
      chk({tag, "_latency"}, W'(edges), W'(W + 2));
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
      if (hold) begin
         @(posedge clk);
         #1;
         chk({tag, "_no_restart"}, W'(busy), W'(0));
         chk({tag, "_hi_kept"}, hi, exp_hi);
      end
   endtask

   initial begin
      logic [2*W-1:0] r;
      logic [W-1:0]   a, b;
      bit             m, u;

      reset = 1'b1; exec = 1'b1; mul = 1'b1; div = 1'b0; is_unsigned = 1'b0;
      write_hi = 1'b0; write_lo = 1'b0; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_stall_forced", W'(stall), W'(0));
      chk("reset_busy", W'(busy), W'(0));
      chk("reset_hi", hi, '0);
      chk("reset_lo", lo, '0);
      drop_req();
      reset = 1'b0;
      #1;
      chk("idle_stall", W'(stall), W'(0));

      do_op("multu_ff", 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001);
      do_op("mult_m3x7", 1, 0, 32'hFFFF_FFFD, 32'd7, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      do_op("divu_7_2", 0, 1, 32'd7, 32'd2, 0, 32'd1, 32'd3);
      do_op("div_m7_2", 0, 0, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("div_ovf", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000);
      do_op("divu_5_0", 0, 1, 32'd5, 32'd0, 0, 32'h0000_0005, 32'hFFFF_FFFF);
      do_op("div_m5_0", 0, 0, 32'hFFFF_FFFB, 32'd0, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

      // MTHI then MTLO, each visible one edge later and never stalling.
      @(posedge clk); #1;
      exec = 1'b1; write_hi = 1'b1; op_a = 32'h1234;
      #1;
      chk("mthi_stall", W'(stall), W'(0));
      @(posedge clk); #1;
      write_hi = 1'b0; write_lo = 1'b1; op_a = 32'hABCD;
      chk("mthi_hi", hi, 32'h1234);
      #1;
      chk("mtlo_stall", W'(stall), W'(0));
      @(posedge clk); #1;
      write_lo = 1'b0; exec = 1'b0;
      chk("mtlo_lo", lo, 32'hABCD);
      chk("mtlo_hi_kept", hi, 32'h1234);

      r = ref_model(1, 0, 32'hFFFF_FF00, 32'h0001_0003);
      do_op("mult_hold", 1, 0, 32'hFFFF_FF00, 32'h0001_0003, 1, r[2*W-1:W], r[W-1:0]);

      // Reset at CALC cycle 10 aborts the operation.
      exec = 1'b1; mul = 1'b1; is_unsigned = 1'b0; op_a = 32'h7777; op_b = 32'h9999;
      @(posedge clk); #1;
      drop_req();
      repeat (9) @(posedge clk);
      #1;
      chk("mid_calc_busy", W'(busy), W'(1));
      reset = 1'b1;
      #1;
      chk("abort_stall_forced", W'(stall), W'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("abort_busy", W'(busy), W'(0));
      chk("abort_stall", W'(stall), W'(0));
      chk("abort_hi", hi, '0);
      chk("abort_lo", lo, '0);
      do_op("multu_2x3", 1, 1, 32'd2, 32'd3, 0, 32'd0, 32'd6);

      for (int i = 0; i < 16; i++) begin
         m = 1'($urandom_range(0, 1));
         u = 1'($urandom_range(0, 1));
         a = (i % 4 == 0) ? W'($urandom_range(0, 100)) : W'($urandom);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 20));
            2:       b = 32'hFFFF_FFFF;
            default: b = W'($urandom);
         endcase
         r = ref_model(m, u, a, b);
         do_op($sformatf("rand%0d_%s%s", i, m ? "mul" : "div", u ? "u" : ""),
               m, u, a, b, 0, r[2*W-1:W], r[W-1:0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide unit with its own sequencing FSM. It owns the HI/LO registers. It executes MULT/MULTU/DIV/DIVU iteratively and services MTHI/MTLO writes. While an operation is in flight it drives the stall input of the control path, freezing fetch/execute until HI/LO are valid. Decoded Mul/Div/Unsigned/WriteHi/WriteLo come from the control block; operands come from the register-file read ports.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- exec  input  1  control FSM is in its execute state; qualifies all requests
- mul  input  1  multiply request (MULT/MULTU)
- div  input  1  divide request (DIV/DIVU)
- is_unsigned  input  1  1 = unsigned operation, 0 = two's-complement
- write_hi  input  1  MTHI: load HI from op_a
- write_lo  input  1  MTLO: load LO from op_a
- op_a  input  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO data)
- op_b  input  WIDTH  rt value (multiplier / divisor)
- stall  output  1  hold the control path; combinational
- busy  output  1  FSM not in IDLE; registered
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- States: IDLE, CALC, FIXUP.
- IDLE:
  - Request = exec & (mul | div). On a request, capture |op_a|, |op_b|, result-sign flags, op type and a zero-divisor flag. Load counter to WIDTH-1 and go to CALC.
  - In the unsigned case, or when an operand is non-negative, the absolute value is the operand itself.
  - mul and div both high: mul wins.
- CALC runs WIDTH cycles, one iteration per cycle:
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
  - The counter decrements each cycle; at 0, go to FIXUP.
- FIXUP, one cycle, then IDLE:
  - Apply sign correction and write HI/LO at the end of the cycle.
  - Multiply: 2·WIDTH product, negated if operand signs differ. HI = upper half, LO = lower half.
  - Divide: LO = quotient, negated if signs differ. HI = remainder, negated if the dividend is negative (remainder takes the dividend's sign).
  - Signed overflow (0x80000000 / -1) needs no special case: LO = 0x80000000, HI = 0.
  - Divide by zero: LO = all ones, HI = original op_a. Sign fixup is bypassed for both signednesses.
- MTHI/MTLO:
  - In IDLE with exec high, write_hi/write_lo load op_a into HI/LO at the next edge. No stall.
  - Both high: both registers load.
  - Ignored outside IDLE, which cannot occur because the control path is stalled.
- Requests seen in CALC/FIXUP are ignored. A decoded mul/div still present in FIXUP does not restart the FSM.
- stall = (IDLE & exec & (mul | div)) | CALC. It is low in FIXUP so the instruction retires on the same edge HI/LO update.
- Reset:
  - State IDLE; hi = lo = 0; busy = 0; counter and accumulators cleared.
  - stall is forced 0 while reset is high.
  - Reset mid-CALC/FIXUP aborts the operation with no HI/LO write, other than the clear to 0.

## Timing
- Accept edge: IDLE to CALC, at the end of the request cycle. stall is already high in the request cycle.
- stall high for exactly WIDTH+1 cycles per mul/div (33 at WIDTH=32): the request cycle plus WIDTH CALC cycles.
- busy high for WIDTH+1 cycles: all CALC cycles plus FIXUP.
- hi/lo valid in the first cycle after FIXUP; total latency request-to-result is WIDTH+2 edges.
- Back-to-back mul/div: the next request is accepted in the first IDLE cycle after FIXUP. No idle gap beyond that.
- A MFHI/MFLO issued right after retirement reads the new values.

## Structure
- The shared package holds:
  - the state enum muldiv_state_t {IDLE, CALC, FIXUP};
  - the constant MULDIV_ITERS = WIDTH;
  - the divide-by-zero quotient constant.
- One sub-module, muldiv_signfix: purely combinational, it computes absolute values on entry and the conditional negation in FIXUP. It is shared by the mul and div paths.
- The FSM, counter, accumulators and HI/LO registers stay in the top module.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> stall high 33 cycles; then HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT -3 × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. DIVU 7 / 2 -> LO = 3, HI = 1.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 5 / 0 and DIV -5 / 0 -> LO = 0xFFFFFFFF; HI = 0x00000005 and 0xFFFFFFFB respectively.
- MTHI 0x1234 then MTLO 0xABCD in IDLE -> HI = 0x1234, LO = 0xABCD one edge after each write, stall never high. Then MULT with mul held through FIXUP -> exactly one operation executes.
- Reset asserted at CALC cycle 10 -> next cycle state IDLE, stall = 0, busy = 0, HI = LO = 0. A following MULTU 2 × 3 completes normally with LO = 6, HI = 0.
